// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM; define SEQ_TIMEOUT_EN for the ack timeout and FAULT state
module cpu_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        imem_ack,
   input  logic [15:0] instr,
   input  logic        dmem_ack,
   input  logic        flag_z,
   output logic        imem_req,
   output logic        ir_load,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        sp_inc,
   output logic        sp_dec,
   output logic        reg_we,
   output logic [2:0]  state,
   output logic [15:0] retired,
   output logic        fault
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd6
   } state_t;
   state_t      r_state;
   logic [3:0]  r_op;
   logic [15:0] r_retired;
   logic        w_mem_op;
   logic        w_end;
   logic        w_tmo;
   assign w_mem_op = (r_op >= 4'd2) && (r_op <= 4'd5);
   assign w_end    = (r_state == S_EXEC) || (r_state == S_WB);
`ifdef SEQ_TIMEOUT_EN
   logic [3:0] r_wait;
   logic       w_waiting;
   assign w_waiting = ((r_state == S_FETCH) && !imem_ack) || ((r_state == S_MEM) && !dmem_ack);
   assign w_tmo     = w_waiting && (r_wait == 4'hF);
   assign fault     = r_state == S_FAULT;
   // consecutive ack-wait cycles; any non-waiting cycle (incl. entry into FETCH/MEM) restarts at zero
   always_ff @(posedge clk) begin
      r_wait <= (rst || !w_waiting) ? 4'd0 : r_wait + 4'd1;
   end
`else
   assign w_tmo = 1'b0;
   assign fault = 1'b0;
`endif
   // state transitions, opcode latch and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_op      <= 4'd0;
         r_retired <= 16'd0;
      end else begin
         if (w_end) r_retired <= r_retired + 16'd1;
         case (r_state)
            S_IDLE:   r_state <= run ? S_FETCH : S_IDLE;
            S_FETCH: begin
               if (imem_ack) begin
                  r_op    <= instr[15:12];
                  r_state <= S_DECODE;
               end else if (w_tmo) r_state <= S_FAULT;
            end
            S_DECODE: r_state <= w_mem_op ? S_MEM : S_EXEC;
            S_MEM: begin
               if (dmem_ack) r_state <= S_WB;
               else if (w_tmo) r_state <= S_FAULT;
            end
            S_EXEC, S_WB: r_state <= run ? S_FETCH : S_IDLE;
            default:  r_state <= S_FAULT;
         endcase
      end
   end
   // strobes decoded from current state, latched opcode and the qualifying inputs
   always_comb begin
      imem_req = r_state == S_FETCH;
      ir_load  = imem_req && imem_ack;
      pc_inc   = imem_req && imem_ack;
      pc_load  = (r_state == S_EXEC) && (r_op == 4'd1) && flag_z;
      dmem_req = r_state == S_MEM;
      dmem_we  = dmem_req && ((r_op == 4'd3) || (r_op == 4'd4));
      sp_dec   = (r_state == S_WB) && (r_op == 4'd4);
      sp_inc   = (r_state == S_WB) && (r_op == 4'd5);
      reg_we   = ((r_state == S_EXEC) && (r_op != 4'd1)) || ((r_state == S_WB) && ((r_op == 4'd2) || (r_op == 4'd5)));
   end
   assign state   = r_state;
   assign retired = r_retired;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer; timeout section follows SEQ_TIMEOUT_EN
module tb_cpu_sequencer;
   logic        clk = 1'b0;
   logic        rst, run, imem_ack, dmem_ack, flag_z;
   logic [15:0] instr;
   logic        imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, sp_inc, sp_dec, reg_we, fault;
   logic [2:0]  state;
   logic [15:0] retired;
   logic [28:0] obs;
   logic [15:0] n_ret = 16'd0;
   logic        exp_fault = 1'b0;
   logic [28:0] exp_q[$];
   string       tag_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   // strobe bits: imem_req ir_load pc_inc pc_load dmem_req dmem_we sp_inc sp_dec reg_we
   localparam logic [8:0] NONE = 9'b000000000;
   localparam logic [8:0] FW   = 9'b100000000;
   localparam logic [8:0] FA   = 9'b111000000;
   localparam logic [8:0] WE   = 9'b000000001;
   localparam logic [8:0] BR   = 9'b000100000;
   localparam logic [8:0] MR   = 9'b000010000;
   localparam logic [8:0] MW   = 9'b000011000;
   localparam logic [8:0] SPD  = 9'b000000010;
   localparam logic [8:0] SPI  = 9'b000000101;
   cpu_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .instr(instr),
      .dmem_ack(dmem_ack), .flag_z(flag_z), .imem_req(imem_req), .ir_load(ir_load),
      .pc_inc(pc_inc), .pc_load(pc_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .sp_inc(sp_inc), .sp_dec(sp_dec), .reg_we(reg_we), .state(state),
      .retired(retired), .fault(fault)
   );
   always #5 clk = ~clk;
   assign obs = {state, imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, sp_inc, sp_dec, reg_we, fault, retired};
   task automatic chk(input string tag, input logic [28:0] act, input logic [28:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got st=%0d strb=%b flt=%b ret=%h, expected st=%0d strb=%b flt=%b ret=%h",
                  tag, act[28:26], act[25:17], act[16], act[15:0], exp[28:26], exp[25:17], exp[16], exp[15:0]);
      end
   endtask
   task automatic step(input string tag, input logic [2:0] st, input logic [8:0] sb, input bit fin);
      exp_q.push_back({st, sb, exp_fault, n_ret});
      tag_q.push_back(tag);
      @(negedge clk);
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge clk);
      #1;
      if (fin) n_ret++;
   endtask
   task automatic fetch(input string tag, input logic [15:0] w);
      instr    = w;
      imem_ack = 1'b1;
      step({tag, "_f"}, 3'd1, FA, 0);
      imem_ack = 1'b0;
      step({tag, "_d"}, 3'd2, NONE, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; flag_z = 1'b0; instr = 16'h0000;
      @(posedge clk);
      #1;
      run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
      step("rst_hold0", 3'd0, NONE, 0);
      step("rst_hold1", 3'd0, NONE, 0);
      rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      step("idle_run", 3'd0, NONE, 0);
      instr = 16'h8123; imem_ack = 1'b1;
      step("alu_f", 3'd1, FA, 0);
      step("alu_d_ackign", 3'd2, NONE, 0);
      imem_ack = 1'b0;
      step("alu_x", 3'd3, WE, 1);
      fetch("brz1", 16'h1000);
      flag_z = 1'b1;
      step("brz1_x", 3'd3, BR, 1);
      fetch("brz0", 16'h1000);
      flag_z = 1'b0;
      step("brz0_x", 3'd3, NONE, 1);
      fetch("push", 16'h4000);
      imem_ack = 1'b1;
      step("push_m0", 3'd4, MW, 0);
      imem_ack = 1'b0;
      step("push_m1", 3'd4, MW, 0);
      step("push_m2", 3'd4, MW, 0);
      dmem_ack = 1'b1;
      step("push_m3", 3'd4, MW, 0);
      dmem_ack = 1'b0;
      step("push_wb", 3'd5, SPD, 1);
      fetch("pop", 16'h5000);
      dmem_ack = 1'b1;
      step("pop_m", 3'd4, MR, 0);
      dmem_ack = 1'b0;
      step("pop_wb", 3'd5, SPI, 1);
      fetch("st", 16'h3abc);
      dmem_ack = 1'b1;
      step("st_m", 3'd4, MW, 0);
      step("st_wb_ackign", 3'd5, NONE, 1);
      dmem_ack = 1'b0;
      for (int i = 0; i < 3; i++) step("ld_fwait", 3'd1, FW, 0);
      fetch("ld", 16'h2000);
      run = 1'b0;
      step("ld_m0", 3'd4, MR, 0);
      dmem_ack = 1'b1;
      step("ld_m1", 3'd4, MR, 0);
      dmem_ack = 1'b0;
      step("ld_wb_norun", 3'd5, WE, 1);
      imem_ack = 1'b1;
      step("idle0", 3'd0, NONE, 0);
      imem_ack = 1'b0;
      step("idle1", 3'd0, NONE, 0);
      run = 1'b1;
      step("idle2_run", 3'd0, NONE, 0);
      fetch("imm", 16'h0abc);
      step("imm_x", 3'd3, WE, 1);
      fetch("shf", 16'h6001);
      step("shf_x", 3'd3, WE, 1);
      fetch("aluf", 16'hf00f);
      flag_z = 1'b1;
      step("aluf_x", 3'd3, WE, 1);
      flag_z = 1'b0;
      fetch("rld", 16'h2000);
      step("rld_m", 3'd4, MR, 0);
      rst = 1'b1; dmem_ack = 1'b1;
      step("rld_m_rst", 3'd4, MR, 0);
      n_ret = 16'd0;
      run = 1'b0;
      step("rst_mem_hold", 3'd0, NONE, 0);
      rst = 1'b0; dmem_ack = 1'b0;
      step("rst_mem_idle", 3'd0, NONE, 0);
      run = 1'b1;
      step("to_fetch", 3'd0, NONE, 0);
      run = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      for (int i = 0; i < 20; i++) begin
         exp_fault = i >= 16;
         step("tmo", (i < 16) ? 3'd1 : 3'd6, (i < 16) ? FW : NONE, 0);
      end
      rst = 1'b1;
      step("tmo_rst", 3'd6, NONE, 0);
      exp_fault = 1'b0;
      rst = 1'b0;
      step("tmo_clr", 3'd0, NONE, 0);
`else
      for (int i = 0; i < 20; i++) step("nowait_limit", 3'd1, FW, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
